// File: rtl/spi_regs_pkg.sv
// Shared constants and types for the SPI configuration target.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package spi_regs_pkg;

  // Frame layout: [15] R/W (1 = write), [14:8] address, [7:0] data.
  localparam int TXN_BITS = 16;
  localparam int ADDR_MSB = TXN_BITS - 2;
  localparam int ADDR_LSB = 8;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_DUTY      = 7'h04;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

endpackage

// File: rtl/sync_edge.sv
// Synchroniser chain for one async input, with level output and edge pulses.
// Latency: SYNC_STAGES clk to level; rise/fall pulse for one clk alongside the new level.
// Backpressure: none; free-running, every input change is tracked.
//
// Ports: clk, rst_n (async active-low), async_in (raw pin),
//        level (synchronised value), rise / fall (single-cycle edge pulses).
module sync_edge #(
  parameter int   SYNC_STAGES = 2,     // must be >= 2
  parameter logic RESET_VAL   = 1'b0   // idle level of the pin
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {SYNC_STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], async_in};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign level = chain[SYNC_STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/spi_peripheral.sv
// Write-only SPI mode-0 target decoding 16-bit frames into five 8-bit config registers.
// Latency: register updates SYNC_STAGES+2 clk edges after the raw ncs rise ending the frame.
// Backpressure: none; malformed, read or out-of-range frames are silently discarded.
//
// Ports: clk, rst_n (async active-low); sclk, copi, ncs (raw async SPI pins);
//        en_reg_out_7_0 (0x00), en_reg_out_15_8 (0x01), en_reg_pwm_7_0 (0x02),
//        en_reg_pwm_15_8 (0x03), pwm_duty_cycle (0x04).
module spi_peripheral
  import spi_regs_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [6:0] MAX_ADDR    = 7'h04
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle
);

  localparam logic [4:0] CNT_FULL = 5'(TXN_BITS);
  localparam logic [4:0] CNT_SAT  = 5'(TXN_BITS + 1);

  // Cycles for the synchronisers and their edge flops to flush reset contents.
  localparam int SETTLE = SYNC_STAGES + 1;
  localparam int SW     = $clog2(SETTLE + 1);

  logic sclk_s, sclk_rise, sclk_fall_unused;
  logic copi_s, copi_rise_unused, copi_fall_unused;
  logic ncs_s, ncs_rise, ncs_fall;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .async_in(sclk),
    .level(sclk_s), .rise(sclk_rise), .fall(sclk_fall_unused)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .async_in(copi),
    .level(copi_s), .rise(copi_rise_unused), .fall(copi_fall_unused)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .async_in(ncs),
    .level(ncs_s), .rise(ncs_rise), .fall(ncs_fall)
  );

  // If ncs is already low when reset releases, the ncs chain (reset to 1)
  // produces a fake falling edge. Frames are only accepted once the chains
  // hold real pin history, so an in-flight frame waits for the next genuine fall.
  logic [SW-1:0] settle_cnt;
  logic          settled;

  assign settled = (settle_cnt == SW'(SETTLE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
    end else if (!settled) begin
      settle_cnt <= settle_cnt + SW'(1);
    end
  end

  state_t              state_q, state_d;
  logic [TXN_BITS-1:0] shreg_q, shreg_d;
  logic [4:0]          bit_cnt_q, bit_cnt_d;
  logic                pend_q, pend_d;   // ncs fell while in COMMIT
  logic                wr_en;

  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_ok;

  assign wr_addr  = shreg_q[ADDR_MSB:ADDR_LSB];
  assign wr_data  = shreg_q[7:0];
  assign frame_ok = (bit_cnt_q == CNT_FULL) && shreg_q[TXN_BITS-1] && (wr_addr <= MAX_ADDR);

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    pend_d    = pend_q;
    wr_en     = 1'b0;
    case (state_q)
      IDLE: begin
        pend_d = 1'b0;
        // A fall seen during COMMIT is no longer an edge here, so fall back on the level.
        if (settled && (ncs_fall || (pend_q && !ncs_s))) begin
          state_d   = SHIFT;
          shreg_d   = '0;
          bit_cnt_d = '0;
        end
      end
      SHIFT: begin
        // ncs_rise wins over a coincident sclk_rise: that bit is dropped.
        if (ncs_rise) begin
          state_d = COMMIT;
        end else if (sclk_rise) begin
          shreg_d = {shreg_q[TXN_BITS-2:0], copi_s};
          if (bit_cnt_q != CNT_SAT) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end
      COMMIT: begin
        state_d = IDLE;
        wr_en   = frame_ok;
        if (ncs_fall) begin
          pend_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      pend_q    <= pend_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_reg_out_7_0  <= 8'h00;
      en_reg_out_15_8 <= 8'h00;
      en_reg_pwm_7_0  <= 8'h00;
      en_reg_pwm_15_8 <= 8'h00;
      pwm_duty_cycle  <= 8'h00;
    end else if (wr_en) begin
      case (wr_addr)
        ADDR_EN_OUT_LO: en_reg_out_7_0  <= wr_data;
        ADDR_EN_OUT_HI: en_reg_out_15_8 <= wr_data;
        ADDR_EN_PWM_LO: en_reg_pwm_7_0  <= wr_data;
        ADDR_EN_PWM_HI: en_reg_pwm_15_8 <= wr_data;
        ADDR_DUTY:      pwm_duty_cycle  <= wr_data;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_peripheral.sv
module tb_spi_peripheral;

  typedef logic [4:0][7:0] regs_t;   // [0]=addr 0x00 ... [4]=addr 0x04

  typedef struct {
    logic [31:0] frame;
    int          nbits;
    regs_t       exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n, sclk, copi, ncs;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  spi_peripheral dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle)
  );

  regs_t act;
  assign act = {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};

  function automatic regs_t regs5(input logic [7:0] r0, r1, r2, r3, r4);
    return {r4, r3, r2, r1, r0};
  endfunction

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%02h, want 0x%02h", name, got, want);
    end
  endtask

  task automatic chk_all(input string name, input regs_t want);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("%s reg%0d", name, i), act[i], want[i]);
    end
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low();
    ncs = 1'b0;
    clk_wait(4);
  endtask

  // Mode 0: data changes while sclk is low, sampled on the rise.
  task automatic spi_bits(input logic [31:0] d, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      copi = d[i];
      clk_wait(4);
      sclk = 1'b1;
      clk_wait(4);
      sclk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [31:0] d, input int n);
    cs_low();
    spi_bits(d, n);
    clk_wait(4);
    ncs = 1'b1;
    clk_wait(8);
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{32'h8480,  16, regs5(8'hF0, 8'h00, 8'h00, 8'h00, 8'h80)};
    vecs[1] = '{32'h04FF,  16, regs5(8'hF0, 8'h00, 8'h00, 8'h00, 8'h80)};  // read
    vecs[2] = '{32'h85AA,  16, regs5(8'hF0, 8'h00, 8'h00, 8'h00, 8'h80)};  // addr 0x05
    vecs[3] = '{32'hFF55,  16, regs5(8'hF0, 8'h00, 8'h00, 8'h00, 8'h80)};  // addr 0x7F
    vecs[4] = '{32'h40AA,  15, regs5(8'hF0, 8'h00, 8'h00, 8'h00, 8'h80)};  // 0x81 + 7 bits
    vecs[5] = '{32'h181AA, 17, regs5(8'hF0, 8'h00, 8'h00, 8'h00, 8'h80)};  // last 16 look valid
    vecs[6] = '{32'h0,      0, regs5(8'hF0, 8'h00, 8'h00, 8'h00, 8'h80)};  // bare ncs pulse
    vecs[7] = '{32'h81C3,  16, regs5(8'hF0, 8'hC3, 8'h00, 8'h00, 8'h80)};
    vecs[8] = '{32'h8011,  16, regs5(8'h11, 8'hC3, 8'h00, 8'h00, 8'h80)};
    vecs[9] = '{32'h8377,  16, regs5(8'h11, 8'hC3, 8'h00, 8'h77, 8'h80)};

    rst_n = 1'b0;
    sclk  = 1'b0;
    copi  = 1'b0;
    ncs   = 1'b1;
    clk_wait(3);
    chk_all("reset", regs5(8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
    rst_n = 1'b1;
    clk_wait(4);

    // First write: exact update latency after the raw ncs rise.
    cs_low();
    spi_bits(32'h80F0, 16);
    clk_wait(4);
    ncs = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("latency early", en_reg_out_7_0, 8'h00);
    @(posedge clk);
    @(negedge clk);
    chk("latency exact", en_reg_out_7_0, 8'hF0);
    clk_wait(4);
    chk_all("first write", regs5(8'hF0, 8'h00, 8'h00, 8'h00, 8'h00));

    for (int v = 0; v < 10; v++) begin
      send_frame(vecs[v].frame, vecs[v].nbits);
      chk_all($sformatf("vec%0d", v), vecs[v].exp);
    end

    // Back-to-back frames, ncs high for a single clk so the second fall lands in COMMIT.
    cs_low();
    spi_bits(32'h8201, 16);
    clk_wait(4);
    ncs = 1'b1;
    clk_wait(1);
    ncs = 1'b0;
    clk_wait(4);
    spi_bits(32'h8302, 16);
    clk_wait(4);
    ncs = 1'b1;
    clk_wait(8);
    chk_all("back2back", regs5(8'h11, 8'hC3, 8'h01, 8'h02, 8'h80));

    // Reset in the middle of a frame; the tail of that frame must be ignored.
    cs_low();
    spi_bits(32'h80, 8);
    rst_n = 1'b0;
    clk_wait(2);
    chk_all("reset mid", regs5(8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
    rst_n = 1'b1;
    spi_bits(32'h33, 8);
    clk_wait(4);
    ncs = 1'b1;
    clk_wait(8);
    chk_all("reset tail", regs5(8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
    send_frame(32'h8155, 16);
    chk_all("after reset", regs5(8'h00, 8'h55, 8'h00, 8'h00, 8'h00));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_peripheral.md
Name: spi_peripheral

Overview:
Write-only SPI target (mode 0) on the three TinyTapeout input pins. It decodes 16-bit write frames into five 8-bit configuration registers. Those registers drive the pwm_peripheral stage directly downstream: output enables, PWM enables and the shared duty cycle. All SPI inputs are asynchronous to clk and are synchronised internally; all register logic runs in the clk domain.

Parameters:
SYNC_STAGES, 2, flip-flop depth of each input synchroniser (minimum 2)
TXN_BITS, 16, bits per valid frame: 1 R/W + 7 address + 8 data
MAX_ADDR, 7'h04, highest implemented register address

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
sclk  input  1  SPI clock, async; wired from ui_in[0]
copi  input  1  SPI data in, async; wired from ui_in[1]
ncs  input  1  SPI chip select, active low, async; wired from ui_in[2]
en_reg_out_7_0  output  8  register 0x00, output enables for out[7:0]
en_reg_out_15_8  output  8  register 0x01, output enables for out[15:8]
en_reg_pwm_7_0  output  8  register 0x02, PWM enables for out[7:0]
en_reg_pwm_15_8  output  8  register 0x03, PWM enables for out[15:8]
pwm_duty_cycle  output  8  register 0x04, duty cycle, 0x00 = 0 %, 0xFF = 100 %

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. Reset clears all five registers to 0x00, the synchronisers to the idle level (sclk=0, copi=0, ncs=1), the shift register, and the bit counter, and returns the FSM to IDLE.
- Synchronisation: sclk, copi and ncs each pass through a SYNC_STAGES flop chain. One extra flop per signal provides edge detection.
  - sclk_rise = synced 1 and previous 0.
  - ncs_fall and ncs_rise are detected the same way.
- Timing contract:
  - SCLK high and low phases are each at least 4 clk periods.
  - ncs falls at least 4 clk periods before the first SCLK rise.
  - ncs rises at least 4 clk periods after the last SCLK fall.
- FSM states and transitions:
  - IDLE: on ncs_fall, clear the shift register and bit_cnt, then go to SHIFT.
  - SHIFT: on each sclk_rise, shift in synced copi MSB-first: shreg <= {shreg[14:0], copi_s}. bit_cnt increments and saturates at 17 (5-bit counter).
  - SHIFT to COMMIT on ncs_rise.
  - SCLK edges seen while ncs is synced high are ignored.
  - COMMIT (lasts 1 cycle): the frame is valid only if bit_cnt == 16, shreg[15] == 1 (write), and shreg[14:8] <= MAX_ADDR. If valid, register[shreg[14:8]] <= shreg[7:0]. Always returns to IDLE.
- Frame field layout: bit 15 = R/W, bits 14:8 = address, bits 7:0 = data.
- Update latency: the register output changes on the clk edge that ends COMMIT. That is SYNC_STAGES+2 clk edges after raw ncs rises, with the edge detected at sync output.
- Discarded frames (registers unchanged, no partial update):
  - read frames (bit 15 = 0);
  - address > 0x04;
  - fewer than 16 SCLK rises;
  - more than 16 SCLK rises;
  - ncs pulses with zero SCLK edges.
- Simultaneous events: ncs_rise and sclk_rise in the same cycle is outside the timing contract. The defined behaviour is that the sclk_rise is dropped and COMMIT uses the current count.
- Back-to-back frames: a new ncs_fall seen in COMMIT is held off one cycle. IDLE samples the synced ncs level: if ncs is low and the previous frame has completed, enter SHIFT. The second frame is not lost.
- Reset mid-frame: the partial frame is discarded and registers return to 0x00. A frame already in flight when rst_n releases is ignored until the next ncs_fall.
- Registers hold their values indefinitely between frames; no read-back path exists.

Decomposition:
- Package spi_regs_pkg holds:
  - address constants ADDR_EN_OUT_LO=7'h00, ADDR_EN_OUT_HI=7'h01, ADDR_EN_PWM_LO=7'h02, ADDR_EN_PWM_HI=7'h03, ADDR_DUTY=7'h04;
  - TXN_BITS;
  - the FSM state enum {IDLE, SHIFT, COMMIT}.
- Sub-module sync_edge (parameter SYNC_STAGES) provides one synchroniser chain with level output plus rise/fall pulses. It is instantiated three times; FSM and register file live in spi_peripheral.

Test Plan:
- Reset, then write frame 0x80F0 (write, addr 0x00, data 0xF0) -> en_reg_out_7_0 = 0xF0 within SYNC_STAGES+2 clk of ncs rise; other four regs stay 0x00.
- Frame 0x8480 (addr 0x04) -> pwm_duty_cycle = 0x80; then frame 0x04FF (read bit 0) -> pwm_duty_cycle stays 0x80.
- Frame 0x85AA (addr 0x05) and frame 0xFF55 (addr 0x7F) -> all five registers unchanged.
- 15-bit frame 0x81 followed by 7 bits, then ncs high; and a 17-bit frame -> en_reg_out_15_8 unchanged in both cases.
- Back-to-back frames 0x8201 then 0x8302 with minimum ncs-high gap -> en_reg_pwm_7_0 = 0x01 and en_reg_pwm_15_8 = 0x02.
- Pulse rst_n low after 8 bits of frame 0x8033, then send full frame 0x8155 -> all regs 0x00 after reset, then en_reg_out_15_8 = 0x55 only.
